// File: rtl/mac_accumulator_if.sv
// Handshake bundle for mac_accumulator: operand input channel and result output channel.
interface mac_accumulator_if;
    logic [3:0]  A;
    logic [3:0]  W;
    logic        IN_VALID;
    logic        IN_READY;
    logic [10:0] S;
    logic        SAT;
    logic        OUT_VALID;
    logic        OUT_READY;

    modport master (
        output A, W, IN_VALID, OUT_READY,
        input  IN_READY, S, SAT, OUT_VALID
    );

    modport slave (
        input  A, W, IN_VALID, OUT_READY,
        output IN_READY, S, SAT, OUT_VALID
    );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate: sums LEN products of an unsigned 4-bit activation
// and a signed 4-bit weight into an 11-bit clamped result, then holds it until accepted.
module mac_accumulator #(
    parameter int unsigned LEN = 8
) (
    input  logic              CLK,
    input  logic              RST,
    mac_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] LEN_C = 7'(LEN);

    state_t             state_q, state_d;
    logic [10:0]        acc_q, acc_d;
    logic [6:0]         cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic               in_ready_s;
    logic               xfer_s;
    logic signed [7:0]  a_ext_s;
    logic signed [7:0]  w_ext_s;
    logic signed [7:0]  prod_s;
    logic [10:0]        base_s;
    logic [11:0]        sum_s;

    // Adds a product to the running sum at 12 bits and clamps into the 11-bit signed range.
    // Bit 11 of the result flags that clamping took place; bits 10:0 are the clamped sum.
    function automatic logic [11:0] sat_add(input logic [10:0] acc, input logic [7:0] p);
        logic signed [11:0] sum;
        sum = $signed({acc[10], acc}) + $signed({{4{p[7]}}, p});
        if (sum > 12'sd1023) begin
            sat_add = {1'b1, 11'h3FF};
        end else if (sum < -12'sd1024) begin
            sat_add = {1'b1, 11'h400};
        end else begin
            sat_add = {1'b0, sum[10:0]};
        end
    endfunction

    // Product and candidate sum; a dot product always starts from zero in IDLE.
    always_comb begin
        a_ext_s = {4'b0000, bus.A};
        w_ext_s = {{4{bus.W[3]}}, bus.W};
        prod_s  = a_ext_s * w_ext_s;
        base_s  = (state_q == IDLE) ? 11'd0 : acc_q;
        sum_s   = sat_add(base_s, prod_s);
    end

    assign in_ready_s = (state_q != HOLD);
    assign xfer_s     = bus.IN_VALID & in_ready_s;

    // Next-state and datapath update for the IDLE / ACC / HOLD sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    acc_d = sum_s[10:0];
                    sat_d = sat_q | sum_s[11];
                    if (LEN_C == 7'd1) begin
                        state_d = HOLD;
                        cnt_d   = 7'd0;
                    end else begin
                        state_d = ACC;
                        cnt_d   = 7'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (xfer_s) begin
                    acc_d = sum_s[10:0];
                    sat_d = sat_q | sum_s[11];
                    if (cnt_q == (LEN_C - 7'd1)) begin
                        state_d = HOLD;
                        cnt_d   = 7'd0;
                    end else begin
                        state_d = ACC;
                        cnt_d   = cnt_q + 7'd1;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            HOLD: begin
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                    acc_d   = 11'd0;
                    cnt_d   = 7'd0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = 11'd0;
                cnt_d   = 7'd0;
                sat_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= 11'd0;
            cnt_q   <= 7'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.IN_READY  = in_ready_s;
    assign bus.OUT_VALID = (state_q == HOLD);
    assign bus.S         = acc_q;
    assign bus.SAT       = sat_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: three instances (LEN 8, 16, 1) share clock and reset.
module tb_mac_accumulator;
    logic CLK;
    logic RST;

    mac_accumulator_if bus8 ();
    mac_accumulator_if bus16 ();
    mac_accumulator_if bus1 ();

    mac_accumulator #(.LEN(8))  dut8  (.CLK(CLK), .RST(RST), .bus(bus8));
    mac_accumulator #(.LEN(16)) dut16 (.CLK(CLK), .RST(RST), .bus(bus16));
    mac_accumulator #(.LEN(1))  dut1  (.CLK(CLK), .RST(RST), .bus(bus1));

    typedef struct {
        int sel;
        int s;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   m_acc[3];
    bit   m_sat[3];
    int   m_cnt[3];
    int   lens[3] = '{8, 16, 1};
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    function automatic logic [10:0] rd_s(int sel);
        case (sel)
            0:       rd_s = bus8.S;
            1:       rd_s = bus16.S;
            default: rd_s = bus1.S;
        endcase
    endfunction

    function automatic logic rd_sat(int sel);
        case (sel)
            0:       rd_sat = bus8.SAT;
            1:       rd_sat = bus16.SAT;
            default: rd_sat = bus1.SAT;
        endcase
    endfunction

    function automatic logic rd_ov(int sel);
        case (sel)
            0:       rd_ov = bus8.OUT_VALID;
            1:       rd_ov = bus16.OUT_VALID;
            default: rd_ov = bus1.OUT_VALID;
        endcase
    endfunction

    function automatic logic rd_ir(int sel);
        case (sel)
            0:       rd_ir = bus8.IN_READY;
            1:       rd_ir = bus16.IN_READY;
            default: rd_ir = bus1.IN_READY;
        endcase
    endfunction

    task automatic drive(int sel, logic [3:0] a, logic [3:0] w, logic iv, logic ordy);
        case (sel)
            0: begin bus8.A = a;  bus8.W = w;  bus8.IN_VALID = iv;  bus8.OUT_READY = ordy;  end
            1: begin bus16.A = a; bus16.W = w; bus16.IN_VALID = iv; bus16.OUT_READY = ordy; end
            default: begin bus1.A = a; bus1.W = w; bus1.IN_VALID = iv; bus1.OUT_READY = ordy; end
        endcase
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 1'b0;
            m_cnt[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_xfer(int sel, int a, int w);
        int sum;
        sum = m_acc[sel] + a * w;
        if (sum > 1023) begin
            sum = 1023;
            m_sat[sel] = 1'b1;
        end else if (sum < -1024) begin
            sum = -1024;
            m_sat[sel] = 1'b1;
        end
        m_acc[sel] = sum;
        m_cnt[sel]++;
        if (m_cnt[sel] == lens[sel]) begin
            exp_q.push_back('{sel: sel, s: sum, sat: m_sat[sel]});
            m_acc[sel] = 0;
            m_sat[sel] = 1'b0;
            m_cnt[sel] = 0;
        end
    endtask

    // One handshaked pair; inputs change 1 time unit after the rising edge.
    task automatic send(int sel, int a, int w, logic ordy);
        int tries;
        logic [31:0] av;
        logic [31:0] wv;
        av = a;
        wv = w;
        tries = 0;
        drive(sel, av[3:0], wv[3:0], 1'b1, ordy);
        while (rd_ir(sel) !== 1'b1 && tries < 20) begin
            @(posedge CLK); #1;
            tries++;
        end
        if (tries >= 20) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout sel=%0d IN_READY never rose", sel);
            drive(sel, 4'd0, 4'd0, 1'b0, 1'b0);
        end else begin
            @(posedge CLK); #1;
            drive(sel, 4'd0, 4'd0, 1'b0, 1'b0);
            model_xfer(sel, a, w);
        end
    endtask

    // Waits for a result, compares it with the scoreboard, accepts it and checks the clear.
    task automatic collect(int sel);
        int tries;
        exp_t it;
        logic [10:0] e;
        tries = 0;
        while (rd_ov(sel) !== 1'b1 && tries < 20) begin
            @(posedge CLK); #1;
            tries++;
        end
        n_vec++;
        if (tries >= 20) begin
            n_err++;
            $display("FAIL out_valid_timeout sel=%0d", sel);
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result sel=%0d got S=%0h", sel, rd_s(sel));
        end else begin
            it = exp_q.pop_front();
            e = 11'(it.s);
            if (rd_s(sel) !== e) begin
                n_err++;
                $display("FAIL result_s sel=%0d got=%0h exp=%0h", sel, rd_s(sel), e);
            end
            n_vec++;
            if (rd_sat(sel) !== it.sat) begin
                n_err++;
                $display("FAIL result_sat sel=%0d got=%0b exp=%0b", sel, rd_sat(sel), it.sat);
            end
            drive(sel, 4'd0, 4'd0, 1'b0, 1'b1);
            @(posedge CLK); #1;
            drive(sel, 4'd0, 4'd0, 1'b0, 1'b0);
            n_vec++;
            if (rd_ov(sel) !== 1'b0) begin
                n_err++;
                $display("FAIL accept_out_valid sel=%0d got=%0b exp=0", sel, rd_ov(sel));
            end
            n_vec++;
            if (rd_s(sel) !== 11'd0 || rd_sat(sel) !== 1'b0 || rd_ir(sel) !== 1'b1) begin
                n_err++;
                $display("FAIL accept_clear sel=%0d S=%0h SAT=%0b IN_READY=%0b exp 0/0/1",
                         sel, rd_s(sel), rd_sat(sel), rd_ir(sel));
            end
        end
    endtask

    // Asserts reset asynchronously, checks outputs before any clock edge, then releases.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rd_s(i) !== 11'd0 || rd_sat(i) !== 1'b0 || rd_ov(i) !== 1'b0 || rd_ir(i) !== 1'b1) begin
                n_err++;
                $display("FAIL reset_state sel=%0d S=%0h SAT=%0b OV=%0b IR=%0b exp 0/0/0/1",
                         i, rd_s(i), rd_sat(i), rd_ov(i), rd_ir(i));
            end
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_positive();
        for (int i = 0; i < 8; i++) send(0, 15, 7, 1'b0);
        n_vec++;
        if (rd_ov(0) !== 1'b1) begin
            n_err++;
            $display("FAIL latency_out_valid got=%0b exp=1", rd_ov(0));
        end
        collect(0);
    endtask

    task automatic test_negative();
        for (int i = 0; i < 8; i++) send(0, 15, -8, 1'b0);
        collect(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) send(1, 15, 7, 1'b0);
        collect(1);
        for (int i = 0; i < 16; i++) send(1, 15, -8, 1'b0);
        collect(1);
        for (int i = 0; i < 10; i++) send(1, 15, 7, 1'b0);
        for (int i = 0; i < 6; i++) send(1, 15, -8, 1'b0);
        collect(1);
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                send(0, 1, 1, 1'b0);
            end else begin
                drive(0, 4'd1, 4'd1, 1'b0, 1'b0);
                @(posedge CLK); #1;
            end
        end
        collect(0);
    endtask

    task automatic test_hold_stall();
        logic [10:0] e;
        for (int i = 0; i < 8; i++) send(0, 2, -3, 1'b0);
        e = 11'(exp_q[0].s);
        for (int c = 0; c < 5; c++) begin
            drive(0, 4'd7, 4'd7, 1'b1, 1'b0);
            @(posedge CLK); #1;
            n_vec++;
            if (rd_ov(0) !== 1'b1 || rd_ir(0) !== 1'b0 || rd_s(0) !== e || rd_sat(0) !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stall c=%0d OV=%0b IR=%0b S=%0h SAT=%0b exp 1/0/%0h/0",
                         c, rd_ov(0), rd_ir(0), rd_s(0), rd_sat(0), e);
            end
        end
        drive(0, 4'd0, 4'd0, 1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_reset_midway();
        for (int i = 0; i < 3; i++) send(0, 2, 3, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(0, 1, -1, 1'b0);
        collect(0);
        for (int i = 0; i < 8; i++) send(0, 3, 3, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(0, 2, 2, 1'b0);
        collect(0);
    endtask

    task automatic test_out_ready_ignored();
        for (int i = 0; i < 8; i++) send(0, 5, 1, 1'b1);
        collect(0);
    endtask

    task automatic test_len_one();
        send(2, 15, -8, 1'b0);
        n_vec++;
        if (rd_ov(2) !== 1'b1 || rd_ir(2) !== 1'b0) begin
            n_err++;
            $display("FAIL len1_hold OV=%0b IR=%0b exp 1/0", rd_ov(2), rd_ir(2));
        end
        collect(2);
        send(2, 3, 5, 1'b0);
        collect(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) send(0, i, i - 4, 1'b0);
        collect(0);
        for (int i = 0; i < 8; i++) send(0, 15 - i, 3, 1'b0);
        collect(0);
    endtask

    initial begin
        CLK = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 4'd0, 4'd0, 1'b0, 1'b0);
        model_clear();
        #2;
        test_reset();
        test_positive();
        test_negative();
        test_saturation();
        test_gapped();
        test_hold_stall();
        test_reset_midway();
        test_out_ready_ignored();
        test_len_one();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected count=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter: LEN, 8, number of products per dot product (legal 1..64).
REQ-002 SHALL have port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: A  input  4  activation operand, unsigned 0..15.
REQ-005 SHALL have port: W  input  4  weight operand, two's complement -8..7.
REQ-006 SHALL have port: IN_VALID  input  1  A/W pair is valid.
REQ-007 SHALL have port: IN_READY  output  1  block accepts a pair this cycle.
REQ-008 SHALL have port: S  output  11  signed accumulated sum, two's complement; S[10] is the sign bit consumed downstream.
REQ-009 SHALL have port: SAT  output  1  sticky saturation flag for the current dot product.
REQ-010 SHALL have port: OUT_VALID  output  1  S/SAT hold a completed dot product.
REQ-011 SHALL have port: OUT_READY  input  1  downstream accepts S.

Function
REQ-012 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-013 SHALL drive IN_READY=1 in IDLE and ACC and IN_READY=0 in HOLD, decoded from state only.
REQ-014 SHALL treat an input transfer as IN_VALID&IN_READY high at a rising CLK edge; cycles without a transfer leave all state unchanged.
REQ-015 SHALL form the product P = A*W as a signed 8-bit value (range -120..105).
REQ-016 SHALL compute the next sum at 12 bits as ACC+P, sign-extended, then clamp it to +1023 if above or to -1024 if below.
REQ-017 SHALL set SAT on any transfer where clamping occurs; SAT then stays set until the result is accepted.
REQ-018 IDLE transfer: ACC<=sat(0+P), CNT<=1; next state HOLD if LEN==1, else ACC.
REQ-019 ACC transfer: ACC<=sat(ACC+P), CNT<=CNT+1; next state HOLD when this is the LEN-th transfer, else ACC.
REQ-020 SHALL drive S directly from the ACC register in all states.
REQ-021 SHALL drive OUT_VALID=1 exactly while in HOLD, i.e. one cycle after the LEN-th transfer.
REQ-022 In HOLD, S and SAT SHALL remain stable until OUT_READY=1.
REQ-023 On OUT_READY=1 in HOLD, the block SHALL clear ACC, CNT and SAT to 0 and return to IDLE, with OUT_VALID=0 the following cycle.
REQ-024 SHALL ignore IN_VALID while in HOLD; the next pair can be accepted no earlier than the cycle after acceptance.
REQ-025 SHALL ignore OUT_READY outside HOLD.
REQ-026 CNT SHALL be 7 bits wide, and SHALL never wrap because it clears on entry to HOLD or acceptance.

Reset
REQ-027 While RST=1, the block SHALL immediately force state=IDLE, ACC=0, CNT=0, SAT=0, giving S=0, OUT_VALID=0 and IN_READY=1.
REQ-028 RST asserted mid-ACC or mid-HOLD SHALL discard the partial or pending result; the first transfer after RST deasserts SHALL start a new dot product.

Verification
REQ-029 LEN=8, 8 transfers of A=15,W=7 -> OUT_VALID=1 one cycle after the 8th transfer, S=840 (11'h348), SAT=0.
REQ-030 LEN=8, 8 transfers of A=15,W=-8 -> S=-960 (11'h440), SAT=0; then OUT_READY=1 -> next cycle OUT_VALID=0, S=0, IN_READY=1.
REQ-031 LEN=16, 16 transfers of A=15,W=7 -> S=1023 (11'h3FF), SAT=1; 16 transfers of A=15,W=-8 -> S=-1024 (11'h400), SAT=1.
REQ-032 LEN=8, with IN_VALID toggling 1/0 per cycle across 16 cycles carrying A=1,W=1 -> only the 8 handshaked pairs count, S=8.
REQ-033 Hold OUT_READY=0 for 5 cycles in HOLD while driving IN_VALID=1 -> S, SAT and OUT_VALID stay constant, IN_READY=0, and no pair is consumed.
REQ-034 Assert RST after 3 transfers of A=2,W=3, release it, then apply 8 transfers of A=1,W=-1 -> S=-8, SAT=0 (the earlier +18 is discarded).
